// File: rtl/data_stack_pkg.sv
// Shared definitions for the data_stack operand stack: stack-effect codes on i_se.
// Code 7 (ROT) is only decoded when DATA_STACK_ROT_EN is defined; otherwise it acts as NONE.
package data_stack_pkg;

  typedef enum logic [2:0] {
    SE_NONE     = 3'd0,
    SE_DROP     = 3'd1,
    SE_PUSH     = 3'd2,
    SE_RPLC     = 3'd3,
    SE_SWAP     = 3'd4,
    SE_POP_RPLC = 3'd5,
    SE_DUP      = 3'd6,
    SE_ROT      = 3'd7
  } se_e;

endpackage

// File: rtl/lifo_spill.sv
// Register-array LIFO holding the stack entries below TOS/NOS.
// Contents are not reset; only the fill count is. Callers guarantee no push when full / pop when empty.
module lifo_spill #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 10
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  logic                             i_wr_top,
  input  logic [WIDTH-1:0]                 i_data,
  output logic [WIDTH-1:0]                 o_top,
  output logic [$clog2(ENTRIES+1)-1:0]     o_count,
  output logic                             o_full,
  output logic                             o_empty
);

  localparam int CW = $clog2(ENTRIES + 1);
  localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CW-1:0] ENTRIES_V = CW'(ENTRIES);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign wr_idx  = AW'(count_q);
  assign rd_idx  = AW'(count_q - CW'(1));
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == ENTRIES_V);
  assign o_count = count_q;
  assign o_top   = o_empty ? '0 : mem_q[rd_idx];

  always_comb begin
    count_d = count_q;
    if (i_push && !o_full)
      count_d = count_q + CW'(1);
    else if (i_pop && !o_empty)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) count_q <= '0;
    else          count_q <= count_d;
  end

  // Write-top rewrites the current top in place (used by ROT); push has priority.
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full)
      mem_q[wr_idx] <= i_data;
    else if (i_wr_top && !o_empty)
      mem_q[rd_idx] <= i_data;
  end

endmodule

// File: rtl/data_stack.sv
// Operand stack upstream of the ALU: TOS/NOS registers, spill LIFO, legality decode, sticky error.
// Define DATA_STACK_ROT_EN to enable code 7 ROT (a b c -> b c a); otherwise code 7 is NONE.
module data_stack
  import data_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 12
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [2:0]                   i_se,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_tos,
  output logic [WIDTH-1:0]             o_nos,
  output logic [$clog2(DEPTH+1)-1:0]   o_depth,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_err
);

  localparam int DW  = $clog2(DEPTH + 1);
  localparam int SE  = DEPTH - 2;
  localparam int SCW = $clog2(SE + 1);
  localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

  logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;

  logic             sp_push, sp_pop, sp_wr;
  logic [WIDTH-1:0] sp_wdata, sp_top;
  logic [SCW-1:0]   sp_cnt;
  logic             sp_full, sp_empty;
  logic             ge1, ge2;
  se_e              se;

  lifo_spill #(
    .WIDTH   (WIDTH),
    .ENTRIES (SE)
  ) u_spill (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_push   (sp_push),
    .i_pop    (sp_pop),
    .i_wr_top (sp_wr),
    .i_data   (sp_wdata),
    .o_top    (sp_top),
    .o_count  (sp_cnt),
    .o_full   (sp_full),
    .o_empty  (sp_empty)
  );

  assign se  = se_e'(i_se);
  assign ge1 = (depth_q >= DW'(1));
  assign ge2 = (depth_q >= DW'(2));

  // Spill is full exactly when the whole stack is full, since it only fills once TOS/NOS are occupied.
  always_comb begin
    tos_d    = tos_q;
    nos_d    = nos_q;
    depth_d  = depth_q;
    err_d    = err_q;
    sp_push  = 1'b0;
    sp_pop   = 1'b0;
    sp_wr    = 1'b0;
    sp_wdata = nos_q;
    case (se)
      SE_DROP: begin
        if (ge1) begin
          tos_d   = nos_q;
          nos_d   = sp_top;
          sp_pop  = !sp_empty;
          depth_d = depth_q - DW'(1);
        end else err_d = 1'b1;
      end
      SE_PUSH: begin
        if (!sp_full) begin
          sp_push = ge2;
          nos_d   = tos_q;
          tos_d   = i_data;
          depth_d = depth_q + DW'(1);
        end else err_d = 1'b1;
      end
      SE_RPLC: begin
        if (ge1) tos_d = i_data;
        else     err_d = 1'b1;
      end
      SE_SWAP: begin
        if (ge2) begin
          tos_d = nos_q;
          nos_d = tos_q;
        end else err_d = 1'b1;
      end
      SE_POP_RPLC: begin
        if (ge2) begin
          tos_d   = i_data;
          nos_d   = sp_top;
          sp_pop  = (sp_cnt != '0);
          depth_d = depth_q - DW'(1);
        end else err_d = 1'b1;
      end
      SE_DUP: begin
        if (ge1 && !sp_full) begin
          sp_push = ge2;
          nos_d   = tos_q;
          depth_d = depth_q + DW'(1);
        end else err_d = 1'b1;
      end
      SE_ROT: begin
`ifdef DATA_STACK_ROT_EN
        if (!sp_empty) begin
          tos_d = sp_top;
          nos_d = tos_q;
          sp_wr = 1'b1;
        end else err_d = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign o_tos   = tos_q;
  assign o_nos   = nos_q;
  assign o_depth = depth_q;
  assign o_empty = (depth_q == '0);
  assign o_full  = (depth_q == DEPTH_V);
  assign o_err   = err_q;

endmodule

// File: tb/tb_data_stack.sv
// Scoreboard bench for data_stack (WIDTH=8, DEPTH=4); expectations follow DATA_STACK_ROT_EN.
module tb_data_stack;

  localparam int W = 8;
  localparam int D = 4;

  localparam logic [2:0] NONE = 3'd0, DROP = 3'd1, PUSH = 3'd2, RPLC = 3'd3,
                         SWAP = 3'd4, POPR = 3'd5, DUP  = 3'd6, ROT  = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   se = 3'd0;
  logic [W-1:0] data = '0;
  logic [W-1:0] tos, nos;
  logic [2:0]   depth;
  logic         empty, full, err;

  always #5 clk = ~clk;

  data_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_se    (se),
    .i_data  (data),
    .o_tos   (tos),
    .o_nos   (nos),
    .o_depth (depth),
    .o_empty (empty),
    .o_full  (full),
    .o_err   (err)
  );

  typedef struct {
    string    name;
    int       tos;
    int       nos;
    int       depth;
    int       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic cmp(input string nm, input string f, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s.%s: got 0x%0h, required 0x%0h", nm, f, act, req);
  endtask

  task automatic check_all(input exp_t e);
    cmp(e.name, "tos",   int'(tos),   e.tos);
    cmp(e.name, "nos",   int'(nos),   e.nos);
    cmp(e.name, "depth", int'(depth), e.depth);
    cmp(e.name, "empty", int'(empty), int'(e.depth == 0));
    cmp(e.name, "full",  int'(full),  int'(e.depth == D));
    cmp(e.name, "err",   int'(err),   e.err);
  endtask

  function automatic exp_t mk(input string n, input int t, input int s, input int d, input int e);
    exp_t x;
    x.name = n; x.tos = t; x.nos = s; x.depth = d; x.err = e;
    return x;
  endfunction

  // Monitor: every posedge that follows an issued op has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_all(e);
      end
    end
  end

  task automatic op(input logic [2:0] c, input logic [W-1:0] v, input string n,
                    input int t, input int s, input int d, input int e);
    @(negedge clk);
    se   = c;
    data = v;
    q.push_back(mk(n, t, s, d, e));
  endtask

  task automatic do_reset(input string n);
    @(negedge clk);
    se    = NONE;
    rst_n = 1'b0;
    @(negedge clk);
    check_all(mk(n, 0, 0, 0, 0));
    rst_n = 1'b1;
  endtask

  initial begin
    int waited;
    do_reset("reset0");
    op(PUSH, 8'h11, "push11", 'h11, 'h00, 1, 0);
    op(PUSH, 8'h22, "push22", 'h22, 'h11, 2, 0);
    op(PUSH, 8'h33, "push33", 'h33, 'h22, 3, 0);
    op(POPR, 8'h55, "poprplc", 'h55, 'h11, 2, 0);
    op(SWAP, 8'h00, "swap", 'h11, 'h55, 2, 0);
    op(PUSH, 8'h66, "push66", 'h66, 'h11, 3, 0);
    op(PUSH, 8'h77, "push77", 'h77, 'h66, 4, 0);
    op(PUSH, 8'h99, "ovf", 'h77, 'h66, 4, 1);
    op(NONE, 8'hEE, "errsticky", 'h77, 'h66, 4, 1);
    op(DUP,  8'h00, "dupfull", 'h77, 'h66, 4, 1);
    op(DROP, 8'h00, "drop1", 'h66, 'h11, 3, 1);
    op(DROP, 8'h00, "drop2", 'h11, 'h55, 2, 1);
    op(DROP, 8'h00, "drop3", 'h55, 'h00, 1, 1);
    op(SWAP, 8'h00, "swapunder", 'h55, 'h00, 1, 1);
    op(DUP,  8'h00, "dup", 'h55, 'h55, 2, 1);
    op(RPLC, 8'h3C, "rplc", 'h3C, 'h55, 2, 1);

    do_reset("reset1");
    op(DROP, 8'h00, "dropempty", 0, 0, 0, 1);
    op(RPLC, 8'h12, "rplcempty", 0, 0, 0, 1);

    do_reset("reset2");
    op(PUSH, 8'h7F, "push7f", 'h7F, 0, 1, 0);
    op(DROP, 8'h00, "dropzero", 0, 0, 0, 0);
    op(PUSH, 8'h01, "push01", 'h01, 0, 1, 0);
    op(PUSH, 8'h02, "push02", 'h02, 'h01, 2, 0);
    op(PUSH, 8'h03, "push03", 'h03, 'h02, 3, 0);
`ifdef DATA_STACK_ROT_EN
    op(ROT,  8'h00, "rot", 'h01, 'h03, 3, 0);
    op(DROP, 8'h00, "rotdrop1", 'h03, 'h02, 2, 0);
    op(DROP, 8'h00, "rotdrop2", 'h02, 0, 1, 0);
    op(ROT,  8'h00, "rotunder", 'h02, 0, 1, 1);
`else
    op(ROT,  8'h00, "rotnone", 'h03, 'h02, 3, 0);
    op(DROP, 8'h00, "rotdrop1", 'h02, 'h01, 2, 0);
    op(DROP, 8'h00, "rotdrop2", 'h01, 0, 1, 0);
    op(ROT,  8'h00, "rotnone2", 'h01, 0, 1, 0);
`endif

    do_reset("reset3");
    op(PUSH, 8'h0A, "push0a", 'h0A, 0, 1, 0);
    op(PUSH, 8'h0B, "push0b", 'h0B, 'h0A, 2, 0);
    op(PUSH, 8'h0C, "push0c", 'h0C, 'h0B, 3, 0);
    @(posedge clk);
    #3;
    se    = PUSH;
    data  = 8'hEE;
    rst_n = 1'b0;
    #1;
    check_all(mk("asyncrst", 0, 0, 0, 0));
    @(negedge clk);
    check_all(mk("rsthold", 0, 0, 0, 0));
    se    = NONE;
    rst_n = 1'b1;
    op(PUSH, 8'hAA, "pushaa", 'hAA, 0, 1, 0);
    op(NONE, 8'h00, "idle", 'hAA, 0, 1, 0);

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
